// File: rtl/hazard_control_unit_pkg.sv
// Shared encodings for the hazard control unit: FSM states and forwarding mux selects.
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_MEMW = 2'b10
  } hcu_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side bundle for the hazard unit: stage register IDs, handshakes and control outputs.
interface hazard_control_unit_if;
  logic [4:0] Rs1D, Rs2D;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic [4:0] RdM, RdW;
  logic       ResultSrcE0, MulE, PCSrcE;
  logic       RegWriteM, RegWriteW;
  logic       DMemReqM, DMemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE;
  logic       BubbleM, BubbleW;
  logic       MulBusy, MemTimeout;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output ResultSrcE0, MulE, PCSrcE, RegWriteM, RegWriteW, DMemReqM, DMemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, BubbleM, BubbleW, MulBusy, MemTimeout
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  ResultSrcE0, MulE, PCSrcE, RegWriteM, RegWriteW, DMemReqM, DMemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, BubbleM, BubbleW, MulBusy, MemTimeout
  );
endinterface

// File: rtl/hazard_control_unit_forward_select.sv
// Forwarding comparator for one execute-stage source register; M-stage result wins over W.
module forward_select
  import hazard_control_unit_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rd_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_regwrite_m,
  input  logic       i_regwrite_w,
  output logic [1:0] o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    if ((i_rs != 5'd0) && (i_rs == i_rd_m) && i_regwrite_m) begin
      o_fwd = FWD_M;
    end else if ((i_rs != 5'd0) && (i_rs == i_rd_w) && i_regwrite_w) begin
      o_fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard controller: forwarding selects, load-use / multiply / memory-wait stalls and flushes.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int MUL_LAT     = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_control_unit_if.slave  hz
);

  localparam logic [3:0] MUL_LAST  = 4'(MUL_LAT - 1);
  localparam logic [7:0] MEM_MAX   = 8'(MEM_TIMEOUT);
  localparam bit         MUL_MULTI = (MUL_LAT > 1);

  hcu_state_e r_state, w_state_nxt;
  logic [3:0] r_mul_cnt, w_mul_cnt_nxt;
  logic [7:0] r_mem_cnt, w_mem_cnt_nxt;
  logic       r_timeout, w_timeout_nxt;
  logic       r_mul_susp, w_mul_susp_nxt;
  logic [1:0] w_fwd_a, w_fwd_b;
  logic       w_mem_stall, w_mul_stall, w_lw_stall;

  forward_select u_fwd_a (
    .i_rs(hz.Rs1E), .i_rd_m(hz.RdM), .i_rd_w(hz.RdW),
    .i_regwrite_m(hz.RegWriteM), .i_regwrite_w(hz.RegWriteW), .o_fwd(w_fwd_a)
  );

  forward_select u_fwd_b (
    .i_rs(hz.Rs2E), .i_rd_m(hz.RdM), .i_rd_w(hz.RdW),
    .i_regwrite_m(hz.RegWriteM), .i_regwrite_w(hz.RegWriteW), .o_fwd(w_fwd_b)
  );

  assign w_mem_stall = hz.DMemReqM & ~hz.DMemReadyM;
  assign w_lw_stall  = hz.ResultSrcE0 & (hz.RdE != 5'd0) &
                       ((hz.RdE == hz.Rs1D) | (hz.RdE == hz.Rs2D));
  assign w_mul_stall = hz.MulE & (((r_state == ST_IDLE) & MUL_MULTI) |
                                  ((r_state == ST_MUL) & (r_mul_cnt < MUL_LAST)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_mul_cnt  <= '0;
      r_mem_cnt  <= '0;
      r_timeout  <= 1'b0;
      r_mul_susp <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mul_cnt  <= w_mul_cnt_nxt;
      r_mem_cnt  <= w_mem_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
      r_mul_susp <= w_mul_susp_nxt;
    end
  end

  // A memory wait entered from MUL parks mul_cnt and remembers to resume the multiply.
  always_comb begin
    w_state_nxt    = r_state;
    w_mul_cnt_nxt  = r_mul_cnt;
    w_mem_cnt_nxt  = r_mem_cnt;
    w_mul_susp_nxt = r_mul_susp;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_stall) begin
          w_state_nxt    = ST_MEMW;
          w_mem_cnt_nxt  = 8'd1;
          w_mul_susp_nxt = 1'b0;
        end else if (hz.MulE && MUL_MULTI) begin
          w_state_nxt   = ST_MUL;
          w_mul_cnt_nxt = 4'd1;
        end
      end
      ST_MUL: begin
        if (w_mem_stall) begin
          w_state_nxt    = ST_MEMW;
          w_mem_cnt_nxt  = 8'd1;
          w_mul_susp_nxt = 1'b1;
        end else if (r_mul_cnt == MUL_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_mul_cnt_nxt = '0;
        end else begin
          w_mul_cnt_nxt = r_mul_cnt + 4'd1;
        end
      end
      ST_MEMW: begin
        if (hz.DMemReadyM) begin
          w_state_nxt    = r_mul_susp ? ST_MUL : ST_IDLE;
          w_mem_cnt_nxt  = '0;
          w_mul_susp_nxt = 1'b0;
        end else if (r_mem_cnt < MEM_MAX) begin
          w_mem_cnt_nxt = r_mem_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_mul_cnt_nxt  = '0;
        w_mem_cnt_nxt  = '0;
        w_mul_susp_nxt = 1'b0;
      end
    endcase
    w_timeout_nxt = r_timeout | (w_mem_cnt_nxt == MEM_MAX);
  end

  // Priority: memory wait, multiply, redirect, load-use; everything reads 0 under reset.
  always_comb begin
    hz.ForwardAE  = rst ? w_fwd_a : FWD_RF;
    hz.ForwardBE  = rst ? w_fwd_b : FWD_RF;
    hz.StallF     = 1'b0;
    hz.StallD     = 1'b0;
    hz.StallE     = 1'b0;
    hz.StallM     = 1'b0;
    hz.FlushD     = 1'b0;
    hz.FlushE     = 1'b0;
    hz.BubbleM    = 1'b0;
    hz.BubbleW    = 1'b0;
    hz.MulBusy    = rst & (r_state != ST_IDLE);
    hz.MemTimeout = rst & r_timeout;
    if (!rst) begin
      hz.StallF = 1'b0;
    end else if (w_mem_stall) begin
      hz.StallF  = 1'b1;
      hz.StallD  = 1'b1;
      hz.StallE  = 1'b1;
      hz.StallM  = 1'b1;
      hz.BubbleW = 1'b1;
    end else if (w_mul_stall) begin
      hz.StallF  = 1'b1;
      hz.StallD  = 1'b1;
      hz.StallE  = 1'b1;
      hz.BubbleM = 1'b1;
    end else if (hz.PCSrcE) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (w_lw_stall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed literal scenarios plus a randomized run against a cycle model.
module tb_hazard_control_unit;

  localparam int MUL_LAT     = 5;
  localparam int MEM_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_control_unit_if hz();

  hazard_control_unit #(.MUL_LAT(MUL_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .hz(hz)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,BubbleM,BubbleW,MulBusy,MemTimeout}
  function automatic logic [9:0] ctl();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE,
            hz.BubbleM, hz.BubbleW, hz.MulBusy, hz.MemTimeout};
  endfunction

  function automatic logic [1:0] fwd_of(input logic [4:0] rs);
    if (rs != 0 && rs == hz.RdM && hz.RegWriteM) return 2'd2;
    if (rs != 0 && rs == hz.RdW && hz.RegWriteW) return 2'd1;
    return 2'd0;
  endfunction

  task automatic clr();
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0;
    hz.RdM = 0; hz.RdW = 0; hz.ResultSrcE0 = 0; hz.MulE = 0; hz.PCSrcE = 0;
    hz.RegWriteM = 0; hz.RegWriteW = 0; hz.DMemReqM = 0; hz.DMemReadyM = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  // Reference model: a multiply in progress is "busy" with an elapsed-cycle count;
  // a memory wait simply pauses it, so resuming needs no separate flag.
  bit m_busy, m_wait, m_to;
  int m_el, m_wc;

  initial begin
    bit mem_s, mul_s, lw_s;
    logic [9:0] e_ctl;
    m_busy = 0; m_wait = 0; m_to = 0; m_el = 0; m_wc = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_busy = 0; m_wait = 0; m_to = 0; m_el = 0; m_wc = 0;
        chk("model_fwdA", hz.ForwardAE, 0);
        chk("model_fwdB", hz.ForwardBE, 0);
        chk("model_ctrl", ctl(), 0);
      end else begin
        mem_s = hz.DMemReqM && !hz.DMemReadyM;
        mul_s = hz.MulE && !m_wait && (m_busy ? (m_el < MUL_LAT - 1) : (MUL_LAT > 1));
        lw_s  = hz.ResultSrcE0 && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
        e_ctl = '0;
        if (mem_s)          e_ctl[9:0] = 10'b1111_0001_00;
        else if (mul_s)     e_ctl[9:0] = 10'b1110_0010_00;
        else if (hz.PCSrcE) e_ctl[9:0] = 10'b0000_1100_00;
        else if (lw_s)      e_ctl[9:0] = 10'b1100_0100_00;
        e_ctl[1] = m_busy || m_wait;
        e_ctl[0] = m_to;
        chk("model_fwdA", hz.ForwardAE, fwd_of(hz.Rs1E));
        chk("model_fwdB", hz.ForwardBE, fwd_of(hz.Rs2E));
        chk("model_ctrl", ctl(), e_ctl);
        if (m_wait) begin
          if (hz.DMemReadyM) m_wait = 0;
          else begin
            if (m_wc < MEM_TIMEOUT) m_wc++;
            if (m_wc == MEM_TIMEOUT) m_to = 1;
          end
        end else if (mem_s) begin
          m_wait = 1;
          m_wc = 1;
          if (m_wc == MEM_TIMEOUT) m_to = 1;
        end else if (m_busy) begin
          if (m_el == MUL_LAT - 1) m_busy = 0;
          else m_el++;
        end else if (hz.MulE && MUL_LAT > 1) begin
          m_busy = 1;
          m_el = 1;
        end
      end
    end
  end

  initial begin
    clr();
    rst = 0;
    hz.RdM = 5; hz.RegWriteM = 1; hz.Rs1E = 5; hz.MulE = 1;
    smp();
    chk("rst_fwdA", hz.ForwardAE, 0);
    chk("rst_ctrl", ctl(), 0);

    cyc(); rst = 1; hz.MulE = 0; hz.RdW = 5; hz.RegWriteW = 1; hz.Rs2E = 0;
    smp();
    chk("fwdA_from_M", hz.ForwardAE, 2);
    chk("fwdB_x0", hz.ForwardBE, 0);
    cyc(); hz.RegWriteM = 0;
    smp();
    chk("fwdA_from_W", hz.ForwardAE, 1);

    cyc(); clr(); hz.ResultSrcE0 = 1; hz.RdE = 7; hz.Rs2D = 7;
    smp();
    chk("lw_stall", {hz.StallF, hz.StallD, hz.FlushE, hz.StallE}, 4'b1110);
    cyc(); clr();
    smp();
    chk("lw_release", {hz.StallF, hz.StallD, hz.FlushE}, 3'b000);

    cyc(); clr(); hz.MulE = 1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
      smp();
      chk("mul_stall_seq", {hz.StallE, hz.BubbleM}, (i == 4 || i == 9) ? 2'b00 : 2'b11);
    end
    cyc(); clr();
    smp();
    chk("mul_done_idle", ctl(), 0);

    cyc(); hz.DMemReqM = 1;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) cyc();
      smp();
      chk("memw_stall", {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.BubbleW}, 5'b11111);
      chk("memw_timeout", hz.MemTimeout, (k > 16) ? 1 : 0);
    end
    cyc(); hz.DMemReadyM = 1;
    smp();
    chk("memw_ready", {hz.StallF, hz.StallM, hz.BubbleW, hz.MemTimeout}, 4'b0001);
    cyc(); clr();
    smp();
    chk("timeout_sticky", hz.MemTimeout, 1);

    cyc(); hz.MulE = 1;
    smp(); chk("frz_pre0", {hz.StallE, hz.BubbleM}, 2'b11);
    cyc();
    smp(); chk("frz_pre1", {hz.StallE, hz.BubbleM}, 2'b11);
    cyc(); hz.DMemReqM = 1;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) cyc();
      smp();
      chk("frz_memw", {hz.StallM, hz.BubbleW, hz.BubbleM, hz.MulBusy}, (j == 0) ? 4'b1101 : 4'b1101);
    end
    cyc(); hz.DMemReadyM = 1;
    smp(); chk("frz_ready", {hz.StallE, hz.StallM}, 2'b00);
    cyc(); hz.DMemReqM = 0; hz.DMemReadyM = 0;
    smp(); chk("frz_resume1", {hz.StallE, hz.BubbleM}, 2'b11);
    cyc();
    smp(); chk("frz_resume2", {hz.StallE, hz.BubbleM}, 2'b11);
    cyc();
    smp(); chk("frz_release", {hz.StallE, hz.BubbleM}, 2'b00);

    cyc(); clr(); hz.PCSrcE = 1; hz.ResultSrcE0 = 1; hz.RdE = 7; hz.Rs1D = 7;
    smp();
    chk("pc_over_lw", {hz.FlushD, hz.FlushE, hz.StallF, hz.StallD}, 4'b1100);

    cyc(); clr(); hz.MulE = 1; hz.RdM = 3; hz.RegWriteM = 1; hz.Rs1E = 3;
    smp(); cyc(); smp(); cyc(); smp();
    chk("mid_mul_busy", {hz.MulBusy, hz.StallE}, 2'b11);
    cyc(); rst = 0;
    smp();
    chk("rst_mid_mul_ctrl", ctl(), 0);
    chk("rst_mid_mul_fwd", hz.ForwardAE, 0);
    cyc(); rst = 1;
    smp();
    chk("after_rst_idle", {hz.StallE, hz.BubbleM, hz.MulBusy, hz.MemTimeout}, 4'b1100);

    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
      hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
      hz.RdE  = 5'($urandom_range(0, 3)); hz.RdM  = 5'($urandom_range(0, 3));
      hz.RdW  = 5'($urandom_range(0, 3));
      hz.RegWriteM   = 1'($urandom_range(0, 1));
      hz.RegWriteW   = 1'($urandom_range(0, 1));
      hz.ResultSrcE0 = ($urandom_range(0, 3) == 0);
      hz.MulE        = ($urandom_range(0, 2) == 0);
      hz.PCSrcE      = ($urandom_range(0, 4) == 0);
      hz.DMemReqM    = ($urandom_range(0, 3) == 0);
      hz.DMemReadyM  = ($urandom_range(0, 2) == 0);
    end

    cyc();
    @(negedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline hazard controller for the 5-stage core.
- Receives the execute-stage hazard outputs (register IDs, load flag, multiply flag) and the memory-stage handshake signals.
- Produces the ForwardAE/ForwardBE mux selects consumed by the execute stage, plus all stall, flush and bubble controls.
- Owns the multi-cycle multiply stall FSM and the data-memory wait FSM, so multiply cycle counting lives here rather than in the execute stage.

Parameters:
- MUL_LAT, 5, total cycles a multiply occupies E (MUL_LAT-1 stall cycles); legal range 1..15.
- MEM_TIMEOUT, 16, memory-wait cycles before MemTimeout asserts; legal range 1..255.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- Rs1D, Rs2D  input  5  source registers in decode
- Rs1E, Rs2E, RdE  input  5  registers of the instruction in execute
- ResultSrcE0  input  1  instruction in E is a load
- MulE  input  1  instruction in E is a multiply
- PCSrcE  input  1  branch taken / jump in E
- RdM, RdW  input  5  destination registers in M and W
- RegWriteM, RegWriteW  input  1  writes pending in M and W
- DMemReqM  input  1  M stage is accessing data memory
- DMemReadyM  input  1  data memory completes this cycle
- ForwardAE, ForwardBE  output  2  00 = register file, 01 = ResultW, 10 = ALUResultM
- StallF, StallD, StallE, StallM  output  1  hold the corresponding pipeline register
- FlushD, FlushE  output  1  clear D / E pipeline register to a bubble
- BubbleM, BubbleW  output  1  force RegWrite/MemWrite to 0 in the entering M / W register
- MulBusy  output  1  multiply FSM not IDLE
- MemTimeout  output  1  memory wait reached MEM_TIMEOUT; sticky until reset

Behaviour:
- Reset (rst=0, async): state=IDLE, mul_cnt=0, mem_cnt=0, MemTimeout=0. All outputs read 0 while reset is held.
- Forwarding (combinational), per source:
  - 10 if RsE!=0, RsE==RdM and RegWriteM.
  - Else 01 if RsE!=0, RsE==RdW and RegWriteW.
  - Else 00.
  - The M match has priority over the W match. x0 is never forwarded.
- Load-use: lw_stall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- States: IDLE, MUL, MEMW.
- mem_stall = DMemReqM & !DMemReadyM (combinational, any state).
- IDLE:
  - mem_stall → MEMW, mem_cnt=1.
  - Else MulE & MUL_LAT>1 → MUL, mul_cnt=1.
  - Else stay.
- MUL:
  - mem_stall freezes mul_cnt (no advance).
  - Otherwise mul_cnt increments each cycle.
  - When mul_cnt==MUL_LAT-1 and no mem_stall, the multiply is released and next state is IDLE.
- MEMW:
  - mem_cnt saturates at MEM_TIMEOUT; MemTimeout is set when mem_cnt reaches MEM_TIMEOUT.
  - On DMemReadyM → return to MUL if a multiply was suspended (a saved flag), else IDLE; mem_cnt=0.
- mul_stall = MulE & ((state==IDLE & MUL_LAT>1) | (state==MUL & mul_cnt<MUL_LAT-1)).
  - Gives exactly MUL_LAT-1 stall cycles.
  - A back-to-back multiply arriving after release restarts from IDLE.
- Output priority (highest first):
  - mem_stall: StallF=StallD=StallE=StallM=1, BubbleW=1. Nothing else asserted; PCSrcE flush is deferred.
  - mul_stall: StallF=StallD=StallE=1, BubbleM=1. Flush is deferred.
  - PCSrcE: FlushD=FlushE=1. Overrides lw_stall; no stalls.
  - lw_stall: StallF=StallD=1, FlushE=1.
- Stall latency: 0 cycles (combinational from inputs and current state). State updates on the rising edge of clk.
- Reset mid-multiply or mid-wait: aborts to IDLE; the suspended flag is cleared.

Decomposition:
- Shared constants file: forward select encodings (FWD_RF, FWD_W, FWD_M) and state encodings.
- One sub-module, forward_select: the combinational comparator for a single source register, instantiated for A and B.

Test Plan:
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=0 → ForwardAE=10, ForwardBE=00. Drop RegWriteM → ForwardAE=01.
- Load in E with RdE=7, Rs2D=7 → one cycle of StallF=StallD=FlushE=1; next cycle all three are 0.
- MulE=1 held, MUL_LAT=5 → StallE=BubbleM=1 for exactly 4 cycles, 0 on the 5th. A back-to-back second multiply gives 4 more stall cycles.
- DMemReqM=1, DMemReadyM=0 for 20 cycles (MEM_TIMEOUT=16) → StallM=BubbleW=1 throughout; MemTimeout rises after 16 cycles and stays set after ready.
- Multiply at mul_cnt=2 while mem_stall is raised for 3 cycles → mul_cnt frozen at 2. After ready, 2 more mul stall cycles follow.
- PCSrcE=1 with lw_stall=1 → FlushD=FlushE=1, StallF=0. Assert rst=0 mid-MUL → all outputs 0 immediately; state IDLE.
